// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller: FSM states, opcodes,
// access-size codes and the instruction-class enum.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_I   = 3'd1,
    CL_LD  = 3'd2,
    CL_ST  = 3'd3,
    CL_ILL = 3'd4
  } class_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic is_mem_class(input class_e cls);
    return (cls == CL_LD) || (cls == CL_ST);
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct3 classifier; shared with the pipelined controller variant.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output class_e     o_class,
  output logic [1:0] o_size
);

  logic w_mem_size_ok;
  logic w_unused_f3;

  // funct3[2] only selects signedness, which the datapath handles on its own.
  assign w_unused_f3   = i_funct3[2];
  assign w_mem_size_ok = (i_funct3[1:0] != 2'b11);
  assign o_size        = i_funct3[1:0];

  always_comb begin
    o_class = CL_ILL;
    case (i_opcode)
      OP_R:     o_class = CL_R;
      OP_I:     o_class = CL_I;
      OP_LOAD:  o_class = w_mem_size_ok ? CL_LD : CL_ILL;
      OP_STORE: o_class = w_mem_size_ok ? CL_ST : CL_ILL;
      default:  o_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/exec/mem/writeback controller with a bounded RAM handshake
// and a sticky fault on RAM timeout.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       ramAck,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       aluSrc,
  output logic       memToReg,
  output logic       ramRdEn,
  output logic       ramWrEn,
  output logic       isByte,
  output logic       isHalf,
  output logic       isWord,
  output logic       illegalInstr,
  output logic       memFault,
  output logic [2:0] state
);

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e     r_state, w_state_nxt;
  class_e     r_class, w_class_nxt, w_dec_class;
  logic [1:0] r_size, w_size_nxt, w_dec_size;
  logic [7:0] r_wait, w_wait_nxt;
  logic       r_fault, w_fault_nxt;
  logic       r_rst_hold;
  logic       w_unused_dwidth;

  assign w_unused_dwidth = ^DWIDTH;

  instr_class_decode u_decode (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .o_class  (w_dec_class),
    .o_size   (w_dec_size)
  );

  // r_rst_hold keeps every strobe low for the cycle following a sampled reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_class    <= CL_R;
      r_size     <= SZ_B;
      r_wait     <= '0;
      r_fault    <= 1'b0;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_class    <= w_class_nxt;
      r_size     <= w_size_nxt;
      r_wait     <= w_wait_nxt;
      r_fault    <= w_fault_nxt;
      r_rst_hold <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_class_nxt = r_class;
    w_size_nxt  = r_size;
    w_wait_nxt  = r_wait;
    w_fault_nxt = r_fault;
    unique case (r_state)
      StFetch: begin
        if (!r_rst_hold) w_state_nxt = StDecode;
      end
      StDecode: begin
        w_class_nxt = w_dec_class;
        w_size_nxt  = w_dec_size;
        w_state_nxt = (w_dec_class == CL_ILL) ? StFetch : StExec;
      end
      StExec: begin
        w_state_nxt = is_mem_class(r_class) ? StMem : StWb;
      end
      StMem: begin
        // An ack on the final allowed cycle still completes normally.
        if (ramAck) begin
          w_wait_nxt  = '0;
          w_state_nxt = (r_class == CL_LD) ? StWb : StFetch;
        end else if (r_wait == WaitLast) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = StHalt;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      StWb:    w_state_nxt = StFetch;
      StHalt:  w_state_nxt = StHalt;
      default: w_state_nxt = StFetch;
    endcase
  end

  always_comb begin
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    regWrite     = 1'b0;
    aluSrc       = 1'b0;
    memToReg     = 1'b0;
    ramRdEn      = 1'b0;
    ramWrEn      = 1'b0;
    isByte       = 1'b0;
    isHalf       = 1'b0;
    isWord       = 1'b0;
    illegalInstr = 1'b0;
    memFault     = r_fault;
    state        = r_state;
    if (!r_rst_hold) begin
      unique case (r_state)
        StFetch: irWrite = 1'b1;
        StDecode: begin
          // Illegal instructions are skipped by advancing the PC straight from decode.
          if (w_dec_class == CL_ILL) begin
            illegalInstr = 1'b1;
            pcWrite      = 1'b1;
          end
        end
        StExec: aluSrc = (r_class != CL_R);
        StMem: begin
          aluSrc  = 1'b1;
          ramRdEn = (r_class == CL_LD);
          ramWrEn = (r_class == CL_ST);
          // A store retires in MEM, so the PC advances on the acknowledging cycle.
          pcWrite = (r_class == CL_ST) && ramAck;
          case (r_size)
            SZ_B:    isByte = 1'b1;
            SZ_H:    isHalf = 1'b1;
            SZ_W:    isWord = 1'b1;
            default: ;
          endcase
        end
        StWb: begin
          regWrite = 1'b1;
          pcWrite  = 1'b1;
          memToReg = (r_class == CL_LD);
          aluSrc   = (r_class != CL_R);
        end
        StHalt:  ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction expected cycle traces built from the controller rules,
// checked every cycle, plus literal strobe-count totals.
module tb_multicycle_controller;

  localparam int MemTimeout = 15;
  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011;
  localparam logic [6:0] OpBad = 7'b1111111;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       ramAck = 1'b0;
  logic irWrite, pcWrite, regWrite, aluSrc, memToReg, ramRdEn, ramWrEn;
  logic isByte, isHalf, isWord, illegalInstr, memFault;
  logic [2:0] state;

  multicycle_controller #(
    .DWIDTH      (32),
    .MEM_TIMEOUT (MemTimeout)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .ramAck       (ramAck),
    .irWrite      (irWrite),
    .pcWrite      (pcWrite),
    .regWrite     (regWrite),
    .aluSrc       (aluSrc),
    .memToReg     (memToReg),
    .ramRdEn      (ramRdEn),
    .ramWrEn      (ramWrEn),
    .isByte       (isByte),
    .isHalf       (isHalf),
    .isWord       (isWord),
    .illegalInstr (illegalInstr),
    .memFault     (memFault),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic irw, pcw, rgw, als, m2r, rde, wre, isb, ish, isw, ill, flt;
  } exp_t;

  typedef struct packed {
    exp_t       e;
    logic       chk;
    logic       rst;
    logic       ack;
    logic [6:0] op;
    logic [2:0] f3;
  } step_t;

  step_t plan[$];
  logic  model_fault = 1'b0;
  exp_t  cur_exp = '0;
  logic  cur_chk = 1'b0;
  logic  run_done = 1'b0;
  logic  final_done = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    cnt_irw = 0, cnt_rdw = 0, cnt_wrb = 0, cnt_ill = 0, cnt_rgw = 0, cnt_flt = 0;
  logic [11:0] act_sb;

  task automatic push(input exp_t e, input logic chk, input logic rst, input logic ack,
                      input logic [6:0] op, input logic [2:0] f3);
    step_t s;
    s.e = e; s.chk = chk; s.rst = rst; s.ack = ack; s.op = op; s.f3 = f3;
    plan.push_back(s);
  endtask

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.flt = model_fault;
    return e;
  endfunction

  // The cycle after a sampled reset: FETCH, every strobe low, fault cleared.
  task automatic add_reset_hold(input logic ack);
    model_fault = 1'b0;
    push(blank(3'd0), 1'b1, 1'b0, ack, '0, '0);
  endtask

  task automatic add_reset();
    push('0, 1'b0, 1'b1, 1'b0, '0, '0);
    add_reset_hold(1'b0);
  endtask

  task automatic add_halt(input int n);
    for (int i = 0; i < n; i++) push(blank(3'd5), 1'b1, 1'b0, (i % 4 == 1), '0, '0);
  endtask

  // waits: MEM cycles without ack before the acking cycle (-1 = never acks).
  // stop_mem: assert reset in that MEM cycle (1-based) and end the instruction there.
  task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input int waits,
                           input int stop_mem);
    exp_t e;
    logic is_r, is_i, is_ld, is_st, legal, ack;
    is_r  = (op == OpR);
    is_i  = (op == OpI);
    is_ld = (op == OpLd);
    is_st = (op == OpSt);
    legal = is_r || is_i || ((is_ld || is_st) && (f3[1:0] != 2'b11));
    e = blank(3'd0); e.irw = 1'b1;
    push(e, 1'b1, 1'b0, 1'b0, op, f3);
    e = blank(3'd1);
    if (!legal) begin
      e.ill = 1'b1; e.pcw = 1'b1;
      push(e, 1'b1, 1'b0, 1'b0, op, f3);
      return;
    end
    push(e, 1'b1, 1'b0, 1'b0, op, f3);
    e = blank(3'd2); e.als = !is_r;
    push(e, 1'b1, 1'b0, 1'b0, op, f3);
    if (is_ld || is_st) begin
      for (int k = 0; k < MemTimeout; k++) begin
        ack = (waits == k);
        e = blank(3'd3);
        e.als = 1'b1; e.rde = is_ld; e.wre = is_st;
        e.isb = (f3[1:0] == 2'b00);
        e.ish = (f3[1:0] == 2'b01);
        e.isw = (f3[1:0] == 2'b10);
        e.pcw = is_st && ack;
        if (stop_mem == k + 1) begin
          push(e, 1'b1, 1'b1, ack, op, f3);
          return;
        end
        push(e, 1'b1, 1'b0, ack, op, f3);
        if (ack) break;
        if (k == MemTimeout - 1) begin
          model_fault = 1'b1;
          return;
        end
      end
    end
    if (!is_st) begin
      e = blank(3'd4);
      e.rgw = 1'b1; e.pcw = 1'b1; e.m2r = is_ld; e.als = !is_r;
      push(e, 1'b1, 1'b0, 1'b0, op, f3);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int idx;
    add_reset();
    add_instr(OpR,  3'b000, 0, 0);
    add_instr(OpI,  3'b001, 0, 0);
    add_instr(OpLd, 3'b010, 2, 0);
    add_instr(OpSt, 3'b000, 0, 0);
    add_instr(OpSt, 3'b001, 1, 0);
    add_instr(OpLd, 3'b100, 0, 0);
    add_instr(OpBad, 3'b000, 0, 0);
    add_instr(OpLd, 3'b011, 0, 0);
    add_instr(OpSt, 3'b111, 0, 0);
    add_instr(OpLd, 3'b101, MemTimeout - 1, 0);
    add_instr(OpSt, 3'b010, 10, 3);
    add_reset_hold(1'b1);
    idx = plan.size();
    add_instr(OpR, 3'b000, 0, 0);
    plan[idx].ack = 1'b1;
    add_instr(OpLd, 3'b010, -1, 0);
    add_halt(20);
    add_reset();
    add_instr(OpR, 3'b111, 0, 0);

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset   = plan[i].rst;
      ramAck  = plan[i].ack;
      opcode  = plan[i].op;
      funct3  = plan[i].f3;
      cur_exp = plan[i].e;
      cur_chk = plan[i].chk;
    end
    @(posedge clk);
    #1;
    cur_chk  = 1'b0;
    run_done = 1'b1;
  end

  always @(negedge clk) begin
    if (cur_chk) begin
      act_sb = {irWrite, pcWrite, regWrite, aluSrc, memToReg, ramRdEn, ramWrEn,
                isByte, isHalf, isWord, illegalInstr, memFault};
      n_checks++;
      if (state !== cur_exp.st) begin
        n_errors++;
        $display("FAIL state @%0t: got %0d, want %0d", $time, state, cur_exp.st);
      end
      n_checks++;
      if (act_sb !== cur_exp[11:0]) begin
        n_errors++;
        $display("FAIL strobes @%0t (ir,pc,rg,als,m2r,rd,wr,b,h,w,ill,flt): got %b, want %b",
                 $time, act_sb, cur_exp[11:0]);
      end
      cnt_irw += int'(irWrite === 1'b1);
      cnt_rdw += int'((ramRdEn === 1'b1) && (isWord === 1'b1));
      cnt_wrb += int'((ramWrEn === 1'b1) && (isByte === 1'b1));
      cnt_ill += int'(illegalInstr === 1'b1);
      cnt_rgw += int'(regWrite === 1'b1);
      cnt_flt += int'(memFault === 1'b1);
    end
    if (run_done && !final_done) begin
      final_done = 1'b1;
      check_lit("irWrite cycles", cnt_irw, 14);
      check_lit("load word cycles", cnt_rdw, 18);
      check_lit("store byte cycles", cnt_wrb, 1);
      check_lit("illegalInstr pulses", cnt_ill, 3);
      check_lit("regWrite cycles", cnt_rgw, 7);
      check_lit("memFault cycles", cnt_flt, 20);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

endmodule
